// File: rtl/gb_display.sv
// Free-running 480x272 TFT timing generator: divides clk down to pclk, produces
// hsync/vsync/de and drives RGB565 colour bars as a stand-in frame source.
module gb_display #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 480,
    parameter int H_FRONT  = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BACK   = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FRONT  = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BACK   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pclk,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] color
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] VS_BEG = 9'(V_ACTIVE + V_FRONT);
    localparam logic [8:0] VS_END = 9'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [8:0]       vcount_q, vcount_d;
    logic             pclk_q, hsync_q, vsync_q, de_q;
    logic [15:0]      color_q;
    logic             tick, pclk_d, h_sync_on, v_sync_on, de_d;

    // Eight equal-width vertical bars across the active line.
    function automatic logic [15:0] bar_color(input logic [9:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 10'(i * (H_ACTIVE / 8))) idx = 3'(i);
        end
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    always_comb begin
        tick   = (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + 1'b1;
        // pclk follows the next divider value so it is high for the upper half count.
        pclk_d = (div_d >= DIV_HALF);

        hcount_d = (hcount_q == H_LAST) ? 10'd0 : hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            vcount_d = (vcount_q == V_LAST) ? 9'd0 : vcount_q + 9'd1;
        end

        h_sync_on = (hcount_q >= HS_BEG) && (hcount_q < HS_END);
        v_sync_on = (vcount_q >= VS_BEG) && (vcount_q < VS_END);
        de_d      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            pclk_q   <= 1'b0;
            hcount_q <= 10'd0;
            vcount_q <= 9'd0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            de_q     <= 1'b0;
            color_q  <= 16'h0000;
        end else begin
            div_q  <= div_d;
            pclk_q <= pclk_d;
            // Outputs register the decode of the pre-increment position: one tick latency.
            if (tick) begin
                hcount_q <= hcount_d;
                vcount_q <= vcount_d;
                hsync_q  <= ~h_sync_on;
                vsync_q  <= ~v_sync_on;
                de_q     <= de_d;
                color_q  <= de_d ? bar_color(hcount_q) : 16'h0000;
            end
        end
    end

    assign pclk  = pclk_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign color = color_q;

endmodule

// File: tb/tb_gb_display.sv
// Scoreboard bench for gb_display: expected pixels are queued at each pixel tick
// and popped at the following pclk rising edge; line/frame timing is also measured.
module tb_gb_display;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 480;
    localparam int H_FRONT  = 2;
    localparam int H_SYNC   = 41;
    localparam int H_BACK   = 2;
    localparam int V_ACTIVE = 6;
    localparam int V_FRONT  = 2;
    localparam int V_SYNC   = 3;
    localparam int V_BACK   = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic        clk = 1'b0;
    logic        reset;
    logic        pclk, hsync, vsync, de;
    logic [15:0] color;

    gb_display #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
        .H_BACK(H_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC),
        .V_BACK(V_BACK)
    ) dut (
        .clk(clk), .reset(reset), .pclk(pclk), .hsync(hsync),
        .vsync(vsync), .de(de), .color(color)
    );

    always #42 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] bar_ref(input int x);
        case (x / (H_ACTIVE / 8))
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [18:0] model(input int x, input int y);
        logic hs, vs, d;
        logic [15:0] c;
        hs = !((x >= H_ACTIVE + H_FRONT) && (x < H_ACTIVE + H_FRONT + H_SYNC));
        vs = !((y >= V_ACTIVE + V_FRONT) && (y < V_ACTIVE + V_FRONT + V_SYNC));
        d  = (x < H_ACTIVE) && (y < V_ACTIVE);
        c  = d ? bar_ref(x) : 16'h0000;
        return {hs, vs, d, c};
    endfunction

    logic [18:0] sb_q[$];
    int px, py, sx, sy, cyc;

    // Timing measurements taken at pclk rising samples.
    int  smp, de_run, hs_run, vs_run, de_frame;
    int  de_fall_idx, hs_rise_idx, vs_fall_idx;
    bit  de_fall_ok, hs_rise_ok, vs_fall_ok;
    logic p_de, p_hs, p_vs;

    task automatic init_state();
        px = 0; py = 0; sx = 0; sy = 0; cyc = 0;
        sb_q.delete();
        smp = 0; de_run = 0; hs_run = 0; vs_run = 0; de_frame = 0;
        de_fall_idx = 0; hs_rise_idx = 0; vs_fall_idx = 0;
        de_fall_ok = 0; hs_rise_ok = 0; vs_fall_ok = 0;
        p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
    endtask

    task automatic measure();
        smp++;
        chk("de_in_vsync", {31'd0, de & ~vsync}, 32'd0);
        if (de) begin de_run++; de_frame++; end
        if (!de && p_de) begin
            chk("de_width", de_run, H_ACTIVE);
            de_run = 0; de_fall_idx = smp; de_fall_ok = 1;
        end
        if (!hsync) hs_run++;
        if (!hsync && p_hs && de_fall_ok) begin
            chk("hs_start", smp - de_fall_idx, H_FRONT);
            de_fall_ok = 0;
        end
        if (hsync && !p_hs) begin
            chk("hs_width", hs_run, H_SYNC);
            if (hs_rise_ok) chk("hs_period", smp - hs_rise_idx, H_TOTAL);
            hs_run = 0; hs_rise_idx = smp; hs_rise_ok = 1;
        end
        if (!vsync) vs_run++;
        if (!vsync && p_vs) begin
            if (vs_fall_ok) chk("vs_period", smp - vs_fall_idx, FRAME);
            chk("de_per_frame", de_frame, H_ACTIVE * V_ACTIVE);
            de_frame = 0; vs_fall_idx = smp; vs_fall_ok = 1;
        end
        if (vsync && !p_vs) begin
            chk("vs_width", vs_run, V_SYNC * H_TOTAL);
            vs_run = 0;
        end
        p_de = de; p_hs = hsync; p_vs = vsync;
    endtask

    task automatic run_cycles(input int n);
        logic [18:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("pclk", {31'd0, pclk}, {31'd0, cyc[0]});
            if (!cyc[0]) begin
                // Pixel tick just happened: outputs now show the pre-increment position.
                e = model(px, py);
                sb_q.push_back(e);
                chk("pix_fall", {13'd0, hsync, vsync, de, color}, {13'd0, e});
                sx = px; sy = py;
                px++;
                if (px == H_TOTAL) begin px = 0; py = (py + 1) % V_TOTAL; end
            end else if (cyc == 1) begin
                chk("pre_tick", {13'd0, hsync, vsync, de, color}, {13'd0, 3'b110, 16'h0000});
            end else if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("pix_rise", {13'd0, hsync, vsync, de, color}, {13'd0, e});
                if (sy == 0 && sx < H_ACTIVE && (sx % 60) == 0) begin
                    case (sx)
                        0:   chk("bar_0",   color, 16'hFFFF);
                        60:  chk("bar_60",  color, 16'hFFE0);
                        120: chk("bar_120", color, 16'h07FF);
                        180: chk("bar_180", color, 16'h07E0);
                        240: chk("bar_240", color, 16'hF81F);
                        300: chk("bar_300", color, 16'hF800);
                        360: chk("bar_360", color, 16'h001F);
                        default: chk("bar_420", color, 16'h0000);
                    endcase
                end
                measure();
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_outs"}, {12'd0, pclk, hsync, vsync, de, color}, {12'd0, 4'b0110, 16'h0000});
    endtask

    initial begin
        int guard;
        init_state();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        reset = 1'b0;

        run_cycles(2 * (2 * FRAME) + 20);

        // Advance to (300, 3), then hit reset asynchronously mid-cycle.
        guard = 0;
        while (!(px == 300 && py == 3 && !cyc[0]) && guard < 4 * FRAME) begin
            run_cycles(1);
            guard++;
        end
        chk("reach_mid", {31'd0, guard < 4 * FRAME}, 32'd1);
        #20;
        reset = 1'b1;
        #1;
        chk_reset("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst_hold");
        @(negedge clk);
        init_state();
        reset = 1'b0;
        run_cycles(2 * (2 * H_TOTAL) + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
